// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter only needs to reach WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Combinational 1-bit full-adder cell used for the per-bit step.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder, LSB first, one full-adder cell plus a carry flop.
// Optional subtract mode (D = A - B - c_in, c_out = borrow) under SERIAL_ADDER_SUB_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] S,
  output logic             c_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic             co_q, co_d;
  logic             sub_q, sub_d;
  logic             sub_sel;
  logic             sum_bit;
  logic             carry;
  logic             accept;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (cy_q),
    .s    (sum_bit),
    .cout (carry)
  );

  assign accept = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    co_d    = co_q;
    sub_d   = sub_q;

    unique case (state_q)
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = WIDTH'({sum_bit, r_q} >> 1);
        cy_d  = carry;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          s_d     = r_d;
          // In subtract mode the carry out is inverted into a borrow.
          co_d    = carry ^ sub_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Subtraction loads ~B with carry ~c_in, i.e. A + ~B + ~c_in.
    if (accept) begin
      state_d = RUN;
      a_d     = A;
      b_d     = B ^ {WIDTH{sub_sel}};
      cy_d    = c_in ^ sub_sel;
      cnt_d   = '0;
      sub_d   = sub_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      sub_q   <= sub_d;
    end
  end

  assign S     = s_q;
  assign c_out = co_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_t, b_t;
  logic         ci_t, sub_t;
  logic [W-1:0] S;
  logic         c_out, busy, done;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_s;
  logic         exp_co;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_t),
    .B     (b_t),
    .c_in  (ci_t),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub_t),
`endif
    .S     (S),
    .c_out (c_out),
    .busy  (busy),
    .done  (done)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic sb);
    logic [W:0] r;
    int d;
    if (sb) begin
      d = int'(a) - int'(b) - int'(ci);
      r = {(d < 0), W'(d)};
    end else begin
      r = a + b + ci;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb);
    a_t   = a;
    b_t   = b;
    ci_t  = ci;
`ifdef SERIAL_ADDER_SUB_EN
    sub_t = sb;
`else
    sub_t = 1'b0 & sb;
`endif
    start = 1'b1;
  endtask

  // Called one time unit after a rising edge; returns at the done cycle.
  task automatic do_run(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sb, input logic hold, input string tag);
    logic [W:0] r;
    set_ops(a, b, ci, sb);
    r = model(a, b, ci, sub_t);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
    chk({tag, "_done_acc"}, 32'(done), 32'd0);
    for (int i = 1; i < W; i++) begin
      @(posedge clk); #1;
      chk({tag, "_busy_run"}, 32'(busy), 32'd1);
      chk({tag, "_done_run"}, 32'(done), 32'd0);
      chk({tag, "_s_hold"}, 32'(S), 32'(exp_s));
    end
    @(posedge clk); #1;
    exp_s  = r[W-1:0];
    exp_co = r[W];
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_s"}, 32'(S), 32'(exp_s));
    chk({tag, "_co"}, 32'(c_out), 32'(exp_co));
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    a_t   = '0;
    b_t   = '0;
    ci_t  = 1'b0;
    sub_t = 1'b0;

    // Reset asserted mid-cycle with no clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst_s", 32'(S), 32'd0);
    chk("rst_co", 32'(c_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    exp_s  = '0;
    exp_co = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    do_run(4'h5, 4'h3, 1'b0, 1'b0, 1'b0, "add53");
    @(posedge clk); #1;
    chk("add53_done_clr", 32'(done), 32'd0);
    chk("add53_idle", 32'(busy), 32'd0);
    do_run(4'hF, 4'h1, 1'b1, 1'b0, 1'b0, "ripF1");
    do_run(4'hF, 4'hF, 1'b1, 1'b0, 1'b0, "ripFF");
    @(posedge clk); #1;

    // start during RUN must be ignored
    set_ops(4'h2, 4'h2, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    set_ops(4'h7, 4'h7, 1'b0, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("ign_busy2", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("ign_busy3", 32'(busy), 32'd1);
    @(posedge clk); #1;
    exp_s  = 4'h4;
    exp_co = 1'b0;
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_s", 32'(S), 32'(exp_s));
    chk("ign_co", 32'(c_out), 32'(exp_co));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("ign_no_done", 32'(done), 32'd0);
      chk("ign_no_busy", 32'(busy), 32'd0);
    end

    // Reset after two RUN cycles aborts the computation.
    set_ops(4'h9, 4'h9, 1'b1, 1'b0);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_s  = '0;
    exp_co = 1'b0;
    chk("mrst_s", 32'(S), 32'd0);
    chk("mrst_co", 32'(c_out), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_done", 32'(done), 32'd0);
      chk("mrst_no_busy", 32'(busy), 32'd0);
      chk("mrst_s_hold", 32'(S), 32'd0);
    end
    do_run(4'hA, 4'h6, 1'b0, 1'b0, 1'b0, "mrst_fresh");

    for (int n = 0; n < 24; n++) begin
      do_run(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0, "rnd");
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        @(posedge clk); #1;
        chk("rnd_idle_done", 32'(done), 32'd0);
        chk("rnd_idle_s", 32'(S), 32'(exp_s));
      end
    end
    @(posedge clk); #1;

    // Back-to-back: start held through DONE, second run subtracts when enabled.
    do_run(4'h3, 4'h5, 1'b0, 1'b0, 1'b1, "b2b1");
    chk("b2b1_s8", 32'(S), 32'h8);
    do_run(4'h3, 4'h5, 1'b0, 1'b1, 1'b0, "b2b2");
`ifdef SERIAL_ADDER_SUB_EN
    chk("b2b2_sE", 32'(S), 32'hE);
    chk("b2b2_borrow", 32'(c_out), 32'd1);
`endif
    @(posedge clk); #1;
    chk("b2b2_done_clr", 32'(done), 32'd0);
    chk("b2b2_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
